// File: rtl/doorlock_pkg.sv
// Purpose: shared constants for the passcode door lock (FSM encoding, status codes, reset passcode).
// Latency: n/a (definitions only).
// Backpressure: n/a.
package doorlock_pkg;

  // FSM state encoding; also driven on the debug "state" port.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ENTRY   = 3'd1;
  localparam logic [2:0] ST_CHECK   = 3'd2;
  localparam logic [2:0] ST_OPEN    = 3'd3;
  localparam logic [2:0] ST_FAIL    = 3'd4;
  localparam logic [2:0] ST_LOCKOUT = 3'd5;
  localparam logic [2:0] ST_SETPW   = 3'd6;

  // seg_out status codes.
  localparam logic [1:0] SEG_IDLE = 2'd0;
  localparam logic [1:0] SEG_OPEN = 2'd1;
  localparam logic [1:0] SEG_FAIL = 2'd2;
  localparam logic [1:0] SEG_LOCK = 2'd3;

  // Passcode loaded at reset: four BCD digits, most significant digit first.
  localparam logic [15:0] DEFAULT_PW = 16'h1234;

  // Only BCD values 0-9 are accepted as digits.
  function automatic logic is_digit(input logic [3:0] num);
    return num <= 4'd9;
  endfunction

endpackage

// File: rtl/dl_timer.sv
// Purpose: loadable down-counter shared by the OPEN, LOCKOUT and entry-timeout intervals.
// Latency: load takes effect on the next edge; done is high while the count is zero.
// Backpressure: none; count=0 freezes the counter, load outranks counting.
// Ports: clk, rst (sync, active-high), load/load_val (reload), count (decrement enable), done.
module dl_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (count && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  // A load value of N yields N+1 cycles before done is seen in the owning state.
  assign done = (cnt == '0);

endmodule

// File: rtl/passcode_ctrl.sv
// Purpose: Moore FSM for a keypad door lock: digit entry, check, timed open, fail count, lockout, passcode change.
// Latency: ps_end at edge k -> CHECK after k -> door_open after k+1; all outputs decode the registered state.
// Backpressure: none; inputs outside the states that consume them are ignored.
// Ports: clk, rst (sync, active-high); ps_start/ps_end/ps_valid/ps_num/ps_change keypad events;
//        door_open, lockout, seg_out (status code), state (debug encoding).
module passcode_ctrl
  import doorlock_pkg::*;
#(
  parameter int PW_LEN   = 4,
  parameter int MAX_FAIL = 3,
  parameter int OPEN_CYC = 50,
  parameter int LOCK_CYC = 200,
  parameter int ENTRY_TO = 100,
  parameter logic [4*PW_LEN-1:0] DEFAULT_PW = doorlock_pkg::DEFAULT_PW
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps_start,
  input  logic       ps_end,
  input  logic       ps_valid,
  input  logic [3:0] ps_num,
  input  logic       ps_change,
  output logic       door_open,
  output logic       lockout,
  output logic [1:0] seg_out,
  output logic [2:0] state
);

  localparam int PW_BITS = 4 * PW_LEN;
  // Digit count saturates at PW_LEN+1 so an over-long entry never aliases to PW_LEN.
  localparam int CW      = $clog2(PW_LEN + 2);
  localparam int FW      = $clog2(MAX_FAIL + 1);
  localparam int T_A     = (OPEN_CYC > LOCK_CYC) ? OPEN_CYC : LOCK_CYC;
  localparam int T_MAX   = (T_A > ENTRY_TO) ? T_A : ENTRY_TO;
  localparam int TW      = $clog2(T_MAX + 1);

  logic [PW_BITS-1:0] digit_buf, buf_nxt;
  logic [PW_BITS-1:0] passcode, pw_nxt;
  logic [CW-1:0]      digit_cnt, cnt_nxt;
  logic [FW-1:0]      fail_cnt, fail_nxt;
  logic [2:0]         state_nxt;
  logic               activity;
  logic               tmr_load;
  logic [TW-1:0]      tmr_val;
  logic               tmr_count;
  logic               tmr_done;

  always_comb begin
    state_nxt = state;
    buf_nxt   = digit_buf;
    cnt_nxt   = digit_cnt;
    fail_nxt  = fail_cnt;
    pw_nxt    = passcode;
    activity  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ps_start) begin
          state_nxt = ST_ENTRY;
          buf_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      ST_ENTRY, ST_SETPW: begin
        // Any keypad event, even an illegal digit, keeps the entry alive.
        activity = ps_start | ps_end | ps_valid;
        if (ps_start) begin
          buf_nxt = '0;
          cnt_nxt = '0;
        end else if (ps_end) begin
          if (state == ST_ENTRY) begin
            state_nxt = ST_CHECK;
          end else begin
            if (digit_cnt == CW'(PW_LEN)) pw_nxt = digit_buf;
            state_nxt = ST_IDLE;
          end
        end else if (ps_valid) begin
          if (is_digit(ps_num)) begin
            buf_nxt = {digit_buf[PW_BITS-5:0], ps_num};
            if (digit_cnt != CW'(PW_LEN + 1)) cnt_nxt = digit_cnt + CW'(1);
          end
        end else if (tmr_done) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if ((digit_cnt == CW'(PW_LEN)) && (digit_buf == passcode)) begin
          state_nxt = ST_OPEN;
          fail_nxt  = '0;
        end else begin
          state_nxt = ST_FAIL;
          if (fail_cnt != FW'(MAX_FAIL)) fail_nxt = fail_cnt + FW'(1);
        end
      end
      ST_OPEN: begin
        if (ps_change) begin
          state_nxt = ST_SETPW;
          buf_nxt   = '0;
          cnt_nxt   = '0;
        end else if (tmr_done) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_FAIL: begin
        state_nxt = (fail_cnt == FW'(MAX_FAIL)) ? ST_LOCKOUT : ST_IDLE;
      end
      ST_LOCKOUT: begin
        if (tmr_done) begin
          state_nxt = ST_IDLE;
          fail_nxt  = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Timer is reloaded on every state change and on each entry keystroke.
  // A load of N gives N+1 cycles in the timed state, hence the -1.
  always_comb begin
    tmr_load = (state_nxt != state) || activity;
    case (state_nxt)
      ST_OPEN:            tmr_val = TW'(OPEN_CYC - 1);
      ST_LOCKOUT:         tmr_val = TW'(LOCK_CYC - 1);
      ST_ENTRY, ST_SETPW: tmr_val = TW'(ENTRY_TO - 1);
      default:            tmr_val = '0;
    endcase
  end

  assign tmr_count = (state == ST_OPEN) || (state == ST_LOCKOUT) ||
                     (state == ST_ENTRY) || (state == ST_SETPW);

  dl_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .done     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      digit_buf <= '0;
      digit_cnt <= '0;
      fail_cnt  <= '0;
      passcode  <= DEFAULT_PW;
    end else begin
      state     <= state_nxt;
      digit_buf <= buf_nxt;
      digit_cnt <= cnt_nxt;
      fail_cnt  <= fail_nxt;
      passcode  <= pw_nxt;
    end
  end

  assign door_open = (state == ST_OPEN);
  assign lockout   = (state == ST_LOCKOUT);

  always_comb begin
    case (state)
      ST_OPEN:    seg_out = SEG_OPEN;
      ST_FAIL:    seg_out = SEG_FAIL;
      ST_LOCKOUT: seg_out = SEG_LOCK;
      default:    seg_out = SEG_IDLE;
    endcase
  end

endmodule
